paddle_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 37 +++
 rtl/paddle_step.sv | 33 +++
 rtl/paddle_ctrl.sv | 149 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong paddle sequencer.
// Pure declarations plus one clamp helper; no state.
package pong_pkg;

  localparam int VPOS_W = 8;

  localparam logic [VPOS_W-1:0] DEF_SPEED       = 8'd4;
  localparam logic [VPOS_W-1:0] DEF_VPOS_MIN    = 8'd0;
  localparam logic [VPOS_W-1:0] DEF_VPOS_MAX    = 8'd224;
  localparam logic [VPOS_W-1:0] DEF_VPOS_CENTER = 8'd112;

  typedef enum logic [2:0] {IDLE, LATCH, CALC1, CALC2, DONE} state_t;

  typedef enum logic [1:0] {HOLD, UP, DOWN, TRACK} step_mode_t;

  typedef struct packed {
    logic              attract_n;
    logic              analog_sel;
    logic              p1_up;
    logic              p1_down;
    logic              p2_up;
    logic              p2_down;
    logic [VPOS_W-1:0] p1_analog;
    logic [VPOS_W-1:0] p2_analog;
  } ctl_t;

  function automatic logic [VPOS_W-1:0] clamp_vpos(input logic [VPOS_W:0]   x,
                                                   input logic [VPOS_W-1:0] lo,
                                                   input logic [VPOS_W-1:0] hi);
    logic [VPOS_W-1:0] r;
    if (x < {1'b0, lo})      r = lo;
    else if (x > {1'b0, hi}) r = hi;
    else                     r = x[VPOS_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/paddle_step.sv
// Combinational saturating step unit: one paddle position moved by mode/target/speed.
// Zero latency; shared between both players by the sequencer.
module paddle_step import pong_pkg::*; #(
  parameter logic [VPOS_W-1:0] VPOS_MIN = DEF_VPOS_MIN,
  parameter logic [VPOS_W-1:0] VPOS_MAX = DEF_VPOS_MAX
) (
  input  logic [VPOS_W-1:0] v_i,
  input  step_mode_t        mode_i,
  input  logic [VPOS_W-1:0] target_i,
  input  logic [VPOS_W-1:0] speed_i,
  output logic [VPOS_W-1:0] v_o
);

  logic [VPOS_W:0] v9, t9, s9, diff9, step9, raw9;

  always_comb begin
    v9    = {1'b0, v_i};
    t9    = {1'b0, clamp_vpos({1'b0, target_i}, VPOS_MIN, VPOS_MAX)};
    s9    = {1'b0, speed_i};
    diff9 = (t9 > v9) ? (t9 - v9) : (v9 - t9);
    // Tracking never overshoots: the slew is capped by the remaining distance.
    step9 = (diff9 < s9) ? diff9 : s9;
    raw9  = v9;
    unique case (mode_i)
      UP:      raw9 = (v9 < (s9 + {1'b0, VPOS_MIN})) ? {1'b0, VPOS_MIN} : (v9 - s9);
      DOWN:    raw9 = v9 + s9;
      TRACK:   raw9 = (t9 > v9) ? (v9 + step9) : (v9 - step9);
      default: raw9 = v9;
    endcase
    v_o = clamp_vpos(raw9, VPOS_MIN, VPOS_MAX);
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-frame paddle sequencer: strobe -> LATCH -> CALC1 (p1) -> CALC2 (p2) -> DONE; one pending strobe kept.
// PADDLE_AUTO_P2_EN lets player 2 track ball_vpos when auto_p2 is set outside attract mode.
module paddle_ctrl import pong_pkg::*; #(
  parameter logic [VPOS_W-1:0] SPEED       = DEF_SPEED,
  parameter logic [VPOS_W-1:0] VPOS_MIN    = DEF_VPOS_MIN,
  parameter logic [VPOS_W-1:0] VPOS_MAX    = DEF_VPOS_MAX,
  parameter logic [VPOS_W-1:0] VPOS_CENTER = DEF_VPOS_CENTER
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              frame_stb,
  input  logic              _attract,
  input  logic              analog_sel,
  input  logic              p1_up,
  input  logic              p1_down,
  input  logic              p2_up,
  input  logic              p2_down,
  input  logic [VPOS_W-1:0] p1_analog,
  input  logic [VPOS_W-1:0] p2_analog,
  input  logic              auto_p2,
  input  logic [VPOS_W-1:0] ball_vpos,
  output logic [VPOS_W-1:0] paddle1_vpos,
  output logic [VPOS_W-1:0] paddle2_vpos,
  output logic              busy,
  output logic              update_done
);

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  ctl_t              ctl_q, ctl_d, ctl_in;
  logic [VPOS_W-1:0] p1_q, p1_d, p2_q, p2_d;

  logic              is_p2, sel_up, sel_dn;
  logic [VPOS_W-1:0] step_v, step_target, step_next, sel_an;
  step_mode_t        step_mode;

`ifdef PADDLE_AUTO_P2_EN
  logic              auto_q;
  logic [VPOS_W-1:0] ball_q;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      auto_q <= 1'b0;
      ball_q <= VPOS_CENTER;
    end else if (state_q == LATCH) begin
      auto_q <= auto_p2;
      ball_q <= ball_vpos;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = ^{auto_p2, ball_vpos};
`endif

  assign ctl_in = '{attract_n: _attract, analog_sel: analog_sel,
                    p1_up: p1_up, p1_down: p1_down, p2_up: p2_up, p2_down: p2_down,
                    p1_analog: p1_analog, p2_analog: p2_analog};

  // One step unit; the state selects whose shadowed controls feed it.
  always_comb begin
    is_p2       = (state_q == CALC2);
    step_v      = is_p2 ? p2_q : p1_q;
    sel_up      = is_p2 ? ctl_q.p2_up : ctl_q.p1_up;
    sel_dn      = is_p2 ? ctl_q.p2_down : ctl_q.p1_down;
    sel_an      = is_p2 ? ctl_q.p2_analog : ctl_q.p1_analog;
    step_mode   = HOLD;
    step_target = VPOS_CENTER;
    if (!ctl_q.attract_n) begin
      step_mode = TRACK;
    end else if (ctl_q.analog_sel) begin
      step_mode   = TRACK;
      step_target = sel_an;
    end else if (sel_up && !sel_dn) begin
      step_mode = UP;
    end else if (sel_dn && !sel_up) begin
      step_mode = DOWN;
    end
`ifdef PADDLE_AUTO_P2_EN
    if (ctl_q.attract_n && is_p2 && auto_q) begin
      step_mode   = TRACK;
      step_target = ball_q;
    end
`endif
  end

  paddle_step #(
    .VPOS_MIN (VPOS_MIN),
    .VPOS_MAX (VPOS_MAX)
  ) u_step (
    .v_i      (step_v),
    .mode_i   (step_mode),
    .target_i (step_target),
    .speed_i  (SPEED),
    .v_o      (step_next)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ctl_d     = ctl_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    unique case (state_q)
      IDLE: begin
        if (frame_stb || pending_q) begin
          state_d   = LATCH;
          pending_d = 1'b0;
        end
      end
      LATCH: begin
        ctl_d   = ctl_in;
        state_d = CALC1;
      end
      CALC1: begin
        p1_d    = step_next;
        state_d = CALC2;
      end
      CALC2: begin
        p2_d    = step_next;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && frame_stb) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ctl_q     <= '0;
      p1_q      <= VPOS_CENTER;
      p2_q      <= VPOS_CENTER;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ctl_q     <= ctl_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
    end
  end

  assign paddle1_vpos = p1_q;
  assign paddle2_vpos = p2_q;
  assign busy         = (state_q != IDLE);
  assign update_done  = (state_q == DONE);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: timeline model of the frame sequence checked every cycle,
// plus literal position/timing expectations.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_stb, attract_n, analog_sel;
  logic       p1_up, p1_down, p2_up, p2_down, auto_p2;
  logic [7:0] p1_analog, p2_analog, ball_vpos;
  logic [7:0] paddle1_vpos, paddle2_vpos;
  logic       busy, update_done;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk          (clk),
    ._reset       (rst_n),
    .frame_stb    (frame_stb),
    ._attract     (attract_n),
    .analog_sel   (analog_sel),
    .p1_up        (p1_up),
    .p1_down      (p1_down),
    .p2_up        (p2_up),
    .p2_down      (p2_down),
    .p1_analog    (p1_analog),
    .p2_analog    (p2_analog),
    .auto_p2      (auto_p2),
    .ball_vpos    (ball_vpos),
    .paddle1_vpos (paddle1_vpos),
    .paddle2_vpos (paddle2_vpos),
    .busy         (busy),
    .update_done  (update_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: positions as plain integers, sequence as edges since the start strobe.
  int m_p1, m_p2, m_t;
  bit m_pend, m_ok = 1'b0;
  bit s_att, s_ana, s_u1, s_d1, s_u2, s_d2, s_auto;
  int s_a1, s_a2, s_ball;

  function automatic int clampv(input int x);
    return (x < 0) ? 0 : ((x > 224) ? 224 : x);
  endfunction

  function automatic int track(input int v, input int t);
    int tc;
    tc = clampv(t);
    if (tc > v) return v + (((tc - v) < 4) ? (tc - v) : 4);
    return v - (((v - tc) < 4) ? (v - tc) : 4);
  endfunction

  function automatic int nxt(input int v, input bit att, input bit ana,
                             input bit up, input bit dn, input int an);
    if (!att) return track(v, 112);
    if (ana) return track(v, an);
    if (up && !dn) return clampv(v - 4);
    if (dn && !up) return clampv(v + 4);
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p1 = 112; m_p2 = 112; m_t = -1; m_pend = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_t < 0) begin
        if (frame_stb || m_pend) begin m_t = 0; m_pend = 1'b0; end
      end else begin
        if (frame_stb) m_pend = 1'b1;
        if (m_t == 0) begin
          s_att = attract_n; s_ana = analog_sel; s_u1 = p1_up; s_d1 = p1_down;
          s_u2 = p2_up; s_d2 = p2_down; s_a1 = int'(p1_analog); s_a2 = int'(p2_analog);
          s_auto = auto_p2; s_ball = int'(ball_vpos);
        end else if (m_t == 1) begin
          m_p1 = nxt(m_p1, s_att, s_ana, s_u1, s_d1, s_a1);
        end else if (m_t == 2) begin
`ifdef PADDLE_AUTO_P2_EN
          if (s_att && s_auto) m_p2 = track(m_p2, s_ball);
          else m_p2 = nxt(m_p2, s_att, s_ana, s_u2, s_d2, s_a2);
`else
          m_p2 = nxt(m_p2, s_att, s_ana, s_u2, s_d2, s_a2);
`endif
        end
        m_t = (m_t == 3) ? -1 : m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_p1", paddle1_vpos, m_p1);
      chk("model_p2", paddle2_vpos, m_p2);
      chk("model_busy", busy, (m_t >= 0) ? 1 : 0);
      chk("model_done", update_done, (m_t == 3) ? 1 : 0);
      if (update_done === 1'b1) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    frame_stb = 1'b1; cyc(1); frame_stb = 1'b0; cyc(5);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
  endtask

  task automatic clr_btn();
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
  endtask

  int d0;
`ifdef PADDLE_AUTO_P2_EN
  int exp_auto[5] = '{116, 120, 124, 128, 130};
`endif

  initial begin
    rst_n = 1'b0; frame_stb = 1'b0; attract_n = 1'b1; analog_sel = 1'b0;
    clr_btn(); auto_p2 = 1'b0; p1_analog = 8'd0; p2_analog = 8'd0; ball_vpos = 8'd0;
    cyc(3); rst_n = 1'b1; cyc(1);
    chk("reset_p1", paddle1_vpos, 112);
    chk("reset_p2", paddle2_vpos, 112);
    chk("reset_busy", busy, 0);
    cyc(6);
    chk("idle_no_done", done_cnt, 0);

    // Single digital frame with exact latency
    p1_up = 1'b1; d0 = done_cnt;
    frame_stb = 1'b1; cyc(1); frame_stb = 1'b0;
    chk("lat_busy_e0", busy, 1);
    cyc(1); chk("lat_p1_e1", paddle1_vpos, 112);
    cyc(1); chk("lat_p1_e2", paddle1_vpos, 108); chk("lat_p2_e2", paddle2_vpos, 112);
    cyc(1); chk("lat_done_e3", update_done, 1); chk("lat_busy_e3", busy, 1);
    cyc(1); chk("lat_busy_e4", busy, 0); chk("lat_done_cnt", done_cnt - d0, 1);

    // Saturation
    clr_btn(); p2_down = 1'b1;
    frame(); chk("sat_p2_first", paddle2_vpos, 116);
    repeat (29) frame();
    chk("sat_p2_max", paddle2_vpos, 224);
    clr_btn(); p1_up = 1'b1;
    repeat (30) frame();
    chk("sat_p1_min", paddle1_vpos, 0);
    p1_down = 1'b1; p2_up = 1'b1; p2_down = 1'b1;
    frame();
    chk("both_p1_hold", paddle1_vpos, 0);
    chk("both_p2_hold", paddle2_vpos, 224);

    // Analog tracking with clamped target and no overshoot
    clr_btn(); do_reset();
    analog_sel = 1'b1; p1_analog = 8'd250; p2_analog = 8'd112;
    repeat (27) frame();
    chk("ana_p1_27", paddle1_vpos, 220);
    frame(); chk("ana_p1_28", paddle1_vpos, 224);
    p1_analog = 8'd222;
    frame(); chk("ana_p1_222", paddle1_vpos, 222);
    chk("ana_p2_hold", paddle2_vpos, 112);

    // Attract mode pulls both paddles to centre regardless of controls
    analog_sel = 1'b0; do_reset();
    p1_up = 1'b1; p2_down = 1'b1;
    repeat (28) frame();
    chk("att_pre_p1", paddle1_vpos, 0);
    chk("att_pre_p2", paddle2_vpos, 224);
    attract_n = 1'b0; p1_up = 1'b1; p2_up = 1'b1;
    frame();
    chk("att_p1_1", paddle1_vpos, 4);
    chk("att_p2_1", paddle2_vpos, 220);
    repeat (27) frame();
    chk("att_p1_end", paddle1_vpos, 112);
    chk("att_p2_end", paddle2_vpos, 112);
    attract_n = 1'b1; clr_btn();

    // Strobe during CALC1 is queued, one during CALC2 is dropped
    p1_down = 1'b1; d0 = done_cnt;
    frame_stb = 1'b1; cyc(1); frame_stb = 1'b0;
    cyc(1); frame_stb = 1'b1; cyc(1);
    cyc(1); frame_stb = 1'b0;
    cyc(1); chk("pend_idle_gap", busy, 0);
    cyc(1); chk("pend_relatch", busy, 1);
    cyc(5);
    chk("pend_p1", paddle1_vpos, 120);
    chk("pend_done_cnt", done_cnt - d0, 2);

    // Controls changed after LATCH do not affect the running sequence
    frame_stb = 1'b1; cyc(1); frame_stb = 1'b0;
    cyc(1); p1_down = 1'b0; p1_up = 1'b1;
    cyc(5);
    chk("shadow_p1", paddle1_vpos, 124);

    // Reset during CALC2 aborts everything
    clr_btn(); p1_down = 1'b1; d0 = done_cnt;
    frame_stb = 1'b1; cyc(1); frame_stb = 1'b0;
    cyc(2); chk("abort_pre_p1", paddle1_vpos, 128);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("abort_p1", paddle1_vpos, 112);
    chk("abort_p2", paddle2_vpos, 112);
    chk("abort_busy", busy, 0);
    cyc(5);
    chk("abort_no_done", done_cnt - d0, 0);

    // Automatic player 2
    clr_btn(); do_reset();
    auto_p2 = 1'b1; ball_vpos = 8'd130;
`ifdef PADDLE_AUTO_P2_EN
    p2_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame(); chk("auto_p2_track", paddle2_vpos, exp_auto[i]);
    end
`else
    frame(); chk("auto_off_hold", paddle2_vpos, 112);
    p2_up = 1'b1;
    frame(); chk("auto_off_up", paddle2_vpos, 108);
`endif
    clr_btn(); auto_p2 = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
